// File: rtl/div32_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, 32 cycles start-to-done (1 for a zero divisor).
// start is sampled only while busy is low; requests made while busy are dropped, not queued.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ZERO,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // The partial remainder stays below the divisor, so after the shift bit WIDTH
    // can only be set when the subtraction succeeds; a 32-bit R register suffices.
    always_comb begin
        r_shift = {r_q, q_q[WIDTH-1]};
        q_shift = {q_q[WIDTH-2:0], 1'b0};
        trial   = r_shift - {1'b0, dsr_q};
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = q_shift | WIDTH'(1);
        end else begin
            r_next = r_shift[WIDTH-1:0];
            q_next = q_shift;
        end
    end

    always_comb begin
        state_d = state_q;
        dsr_d   = dsr_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dsr_d   = divisor;
                    r_d     = '0;
                    q_d     = dividend;
                    cnt_d   = '0;
                    state_d = (divisor == '0) ? S_ZERO : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    quot_d  = q_next;
                    rem_d   = r_next;
                    dz_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_ZERO: begin
                // Q still holds the untouched dividend captured at accept.
                quot_d  = '1;
                rem_d   = q_q;
                dz_d    = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dsr_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dsr_q   <= dsr_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_ZERO);
    assign done      = (state_q == S_DONE);

endmodule
